// File: rtl/led_pattern_shifter.sv
// LED pattern engine: loads one of two patterns, then shifts, rotates or bounces it
// at a programmable step rate, flagging bits that fall off or wrap around an edge.
module led_pattern_shifter #(
   parameter int WIDTH = 8,
   parameter int DIV_W = 24
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             load,
   input  logic             load_sel,
   input  logic [WIDTH-1:0] pat_a,
   input  logic [WIDTH-1:0] pat_b,
   input  logic [2:0]       mode,
   input  logic             enable,
   input  logic [DIV_W-1:0] div,
   output logic [WIDTH-1:0] led,
   output logic             step,
   output logic             edge_evt,
   output logic             dir
);

   localparam logic [2:0] MODE_HOLD   = 3'b000;
   localparam logic [2:0] MODE_SHL    = 3'b001;
   localparam logic [2:0] MODE_SHR    = 3'b010;
   localparam logic [2:0] MODE_ROL    = 3'b011;
   localparam logic [2:0] MODE_ROR    = 3'b100;
   localparam logic [2:0] MODE_BOUNCE = 3'b101;

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] led_q, led_d;
   logic             step_q, step_d;
   logic             evt_q, evt_d;
   logic             dir_q, dir_d;
   logic             tick;

   // >= rather than == so that lowering div mid-count cannot skip a tick.
   assign tick = enable && (cnt_q >= div);

   always_comb begin
      cnt_d  = cnt_q;
      led_d  = led_q;
      dir_d  = dir_q;
      step_d = 1'b0;
      evt_d  = 1'b0;
      if (load) begin
         led_d = load_sel ? pat_b : pat_a;
         cnt_d = '0;
         dir_d = 1'b0;
      end else if (tick) begin
         cnt_d  = '0;
         step_d = 1'b1;
         case (mode)
            MODE_SHL: begin
               led_d = led_q << 1;
               evt_d = led_q[WIDTH-1];
            end
            MODE_SHR: begin
               led_d = led_q >> 1;
               evt_d = led_q[0];
            end
            MODE_ROL: begin
               led_d = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
               evt_d = led_q[WIDTH-1];
            end
            MODE_ROR: begin
               led_d = {led_q[0], led_q[WIDTH-1:1]};
               evt_d = led_q[0];
            end
            MODE_BOUNCE: begin
               // Only the edge we are travelling toward can reverse us; an all-zero
               // pattern shifts to zero and never reverses.
               if (!dir_q) begin
                  if (led_q[WIDTH-1]) begin
                     dir_d = 1'b1;
                     led_d = led_q >> 1;
                     evt_d = 1'b1;
                  end else begin
                     led_d = led_q << 1;
                  end
               end else begin
                  if (led_q[0]) begin
                     dir_d = 1'b0;
                     led_d = led_q << 1;
                     evt_d = 1'b1;
                  end else begin
                     led_d = led_q >> 1;
                  end
               end
            end
            default: led_d = led_q;
         endcase
      end else if (enable) begin
         cnt_d = cnt_q + DIV_W'(1);
      end
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         cnt_q  <= '0;
         led_q  <= '0;
         step_q <= 1'b0;
         evt_q  <= 1'b0;
         dir_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         led_q  <= led_d;
         step_q <= step_d;
         evt_q  <= evt_d;
         dir_q  <= dir_d;
      end
   end

   assign led      = led_q;
   assign step     = step_q;
   assign edge_evt = evt_q;
   assign dir      = dir_q;

endmodule

// File: tb/tb_led_pattern_shifter.sv
// Bench for led_pattern_shifter: a behavioural model queues the expected outputs of
// every clocked cycle and they are compared after the edge, plus directed spot checks.
module tb_led_pattern_shifter;

   localparam int WIDTH = 8;
   localparam int DIV_W = 24;

   logic             clk = 1'b0;
   logic             clr_n;
   logic             load;
   logic             load_sel;
   logic [WIDTH-1:0] pat_a;
   logic [WIDTH-1:0] pat_b;
   logic [2:0]       mode;
   logic             enable;
   logic [DIV_W-1:0] div;
   logic [WIDTH-1:0] led;
   logic             step;
   logic             edge_evt;
   logic             dir;

   led_pattern_shifter #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
      .clk      (clk),
      .clr_n    (clr_n),
      .load     (load),
      .load_sel (load_sel),
      .pat_a    (pat_a),
      .pat_b    (pat_b),
      .mode     (mode),
      .enable   (enable),
      .div      (div),
      .led      (led),
      .step     (step),
      .edge_evt (edge_evt),
      .dir      (dir)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [WIDTH-1:0] led;
      logic             step;
      logic             evt;
      logic             dir;
   } exp_t;

   exp_t             sb_q[$];
   int               checks = 0;
   int               errors = 0;

   logic [WIDTH-1:0] m_led;
   logic             m_dir;
   int               m_cnt;
   int               nsteps;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_led = '0;
      m_dir = 1'b0;
      m_cnt = 0;
   endtask

   // One clock: predict from the current inputs, clock the DUT, compare.
   task automatic cyc(input string tag);
      exp_t e;
      exp_t g;
      e = '0;
      if (load) begin
         m_led = load_sel ? pat_b : pat_a;
         m_cnt = 0;
         m_dir = 1'b0;
      end else if (enable && (m_cnt >= int'(div))) begin
         m_cnt  = 0;
         e.step = 1'b1;
         unique case (mode)
            3'd1: begin e.evt = m_led[7]; m_led = {m_led[6:0], 1'b0}; end
            3'd2: begin e.evt = m_led[0]; m_led = {1'b0, m_led[7:1]}; end
            3'd3: begin e.evt = m_led[7]; m_led = {m_led[6:0], m_led[7]}; end
            3'd4: begin e.evt = m_led[0]; m_led = {m_led[0], m_led[7:1]}; end
            3'd5: begin
               if (m_dir == 1'b0 && m_led[7]) begin
                  m_dir = 1'b1; e.evt = 1'b1; m_led = {1'b0, m_led[7:1]};
               end else if (m_dir == 1'b1 && m_led[0]) begin
                  m_dir = 1'b0; e.evt = 1'b1; m_led = {m_led[6:0], 1'b0};
               end else if (m_dir == 1'b0) begin
                  m_led = {m_led[6:0], 1'b0};
               end else begin
                  m_led = {1'b0, m_led[7:1]};
               end
            end
            default: ;
         endcase
      end else if (enable) begin
         m_cnt++;
      end
      e.led = m_led;
      e.dir = m_dir;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      g = {led, step, edge_evt, dir};
      if (sb_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb_q.pop_front();
         chk({tag, "_out"}, 32'(g), 32'(e));
      end
      if (step) nsteps++;
   endtask

   task automatic do_load(input logic sel, input logic [WIDTH-1:0] p, input logic [2:0] m);
      load = 1'b1; load_sel = sel; mode = m;
      if (sel) pat_b = p; else pat_a = p;
      cyc("load");
      load = 1'b0;
   endtask

   initial begin
      clr_n = 1'b0; load = 1'b0; load_sel = 1'b0; pat_a = '0; pat_b = '0;
      mode = 3'd0; enable = 1'b0; div = '0;
      model_reset();
      #22;
      chk("rst_led", 32'(led), 32'h0);
      chk("rst_step", 32'(step), 32'h0);
      chk("rst_evt", 32'(edge_evt), 32'h0);
      chk("rst_dir", 32'(dir), 32'h0);
      clr_n = 1'b1;
      #4;

      // Load both patterns
      do_load(1'b0, 8'h80, 3'd0);
      chk("ld_a", 32'(led), 32'h80);
      do_load(1'b1, 8'h01, 3'd0);
      chk("ld_b", 32'(led), 32'h01);

      // Rotate left then right, div=0
      enable = 1'b1; div = '0;
      do_load(1'b0, 8'h80, 3'd3);
      cyc("rol");
      chk("rol_wrap", 32'({led, step, edge_evt}), 32'({8'h01, 1'b1, 1'b1}));
      cyc("rol");
      chk("rol_2", 32'({led, edge_evt}), 32'({8'h02, 1'b0}));
      do_load(1'b1, 8'h01, 3'd4);
      cyc("ror");
      chk("ror_wrap", 32'({led, edge_evt}), 32'({8'h80, 1'b1}));

      // Logical right and left
      do_load(1'b0, 8'h03, 3'd2);
      for (int i = 0; i < 3; i++) cyc("shr");
      chk("shr_zero", 32'({led, edge_evt}), 32'({8'h00, 1'b0}));
      do_load(1'b0, 8'hC1, 3'd1);
      for (int i = 0; i < 3; i++) cyc("shl");

      // Bounce from 0x40 through both reversals
      do_load(1'b0, 8'h40, 3'd5);
      cyc("bnc");
      cyc("bnc");
      chk("bnc_rev1", 32'({led, edge_evt, dir}), 32'({8'h40, 1'b1, 1'b1}));
      for (int i = 0; i < 7; i++) cyc("bnc");
      chk("bnc_rev0", 32'({led, edge_evt, dir}), 32'({8'h02, 1'b1, 1'b0}));
      // dir kept across a mode change, then bounce on a zero pattern
      mode = 3'd0; cyc("hold");
      mode = 3'd5; for (int i = 0; i < 3; i++) cyc("bnc");
      do_load(1'b0, 8'h00, 3'd5);
      for (int i = 0; i < 2; i++) cyc("bnc0");

      // Prescaler, div=3: one step per 4 cycles
      div = 24'd3;
      do_load(1'b1, 8'h01, 3'd3);
      nsteps = 0;
      for (int i = 0; i < 12; i++) cyc("pre");
      chk("pre_nsteps", 32'(nsteps), 32'd3);
      cyc("pre");
      enable = 1'b0;
      nsteps = 0;
      for (int i = 0; i < 10; i++) cyc("frz");
      chk("frz_nsteps", 32'(nsteps), 32'd0);
      enable = 1'b1;
      // Lower div below the running count
      div = 24'd9; for (int i = 0; i < 5; i++) cyc("div");
      div = 24'd1; for (int i = 0; i < 4; i++) cyc("div");
      // Load exactly on a tick cycle
      div = 24'd3;
      for (int i = 0; i < 8 && m_cnt < int'(div); i++) cyc("pre");
      pat_a = 8'h3C; load = 1'b1; load_sel = 1'b0;
      cyc("ld_tick");
      load = 1'b0;
      chk("ld_tick", 32'({led, step, edge_evt}), 32'({8'h3C, 1'b0, 1'b0}));
      for (int i = 0; i < 5; i++) cyc("pre");

      // Async reset mid-bounce with dir=1, led=0x10
      div = '0;
      do_load(1'b0, 8'h20, 3'd5);
      for (int i = 0; i < 5; i++) cyc("bnc");
      chk("pre_rst", 32'({led, dir}), 32'({8'h10, 1'b1}));
      #2 clr_n = 1'b0;
      #1;
      chk("arst_led", 32'(led), 32'h0);
      chk("arst_dir", 32'(dir), 32'h0);
      model_reset();
      enable = 1'b0;
      #3 clr_n = 1'b1;
      @(posedge clk); #1;
      enable = 1'b1;
      // First tick after reset needs div+1 enabled cycles
      div = 24'd2;
      mode = 3'd6;
      for (int i = 0; i < 4; i++) cyc("post_rst");

      // Reserved mode 110 holds but still steps
      div = '0;
      do_load(1'b0, 8'h5A, 3'd6);
      cyc("rsv");
      chk("rsv6", 32'({led, step, edge_evt}), 32'({8'h5A, 1'b1, 1'b0}));
      mode = 3'd7; for (int i = 0; i < 2; i++) cyc("rsv");

      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout t=%0t", $time);
      $fatal(1, "timeout");
   end

endmodule
